nes_pio_arbiter: RTL and testbench



---
 rtl/nes_pio_arbiter.sv | 148 ++++++++++++++
 tb/tb_nes_pio_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pio_arbiter.sv
// nes_pio_arbiter: round-robin arbiter that lets two Avalon-MM requesters
// share the single output-PIO slave port of the NES SoC.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   rN_req/wr/addr/wdata requester N access request and payload (N = 0, 1)
//   rN_ack, rN_rdata    one-cycle completion pulse and captured read data
//   m_address, m_chipselect, m_write_n, m_writedata, m_readdata
//                       slave-side Avalon-MM interface (readdata zero wait)
//   m_waitrequest       slave stall input, present only with NES_PIO_ARB_WAIT_EN
//   busy                high whenever the arbiter is not idle
//
// Build option: define NES_PIO_ARB_WAIT_EN to add m_waitrequest and let the
// slave stretch the ACCESS phase.
module nes_pio_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
`ifdef NES_PIO_ARB_WAIT_EN
  input  logic              m_waitrequest,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_grant;  // winner of the current / most recent access

  state_t              w_state_nxt;
  logic                w_last_nxt;
  logic                w_win;
  logic                w_hold;
  logic                w_capture;
  logic                w_cs_nxt;
  logic                w_wn_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_ack0_nxt;
  logic                w_ack1_nxt;

  // Slave stall: only meaningful when the wait option is built in.
`ifdef NES_PIO_ARB_WAIT_EN
  assign w_hold = m_waitrequest;
`else
  assign w_hold = 1'b0;
`endif

  // Round-robin pick: on a tie the requester that did not win last time.
  assign w_win = (r0_req && r1_req) ? ~r_last_grant : ~r0_req;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_capture   = 1'b0;
    w_cs_nxt    = 1'b0;
    w_wn_nxt    = 1'b1;
    w_addr_nxt  = m_address;
    w_wdata_nxt = m_writedata;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r0_req || r1_req) begin
          w_state_nxt = ACCESS;
          w_last_nxt  = w_win;
          w_cs_nxt    = 1'b1;
          // The output registers double as the latched transaction.
          w_wn_nxt    = w_win ? ~r1_wr    : ~r0_wr;
          w_addr_nxt  = w_win ? r1_addr   : r0_addr;
          w_wdata_nxt = w_win ? r1_wdata  : r0_wdata;
        end
      end
      ACCESS: begin
        if (w_hold) begin
          w_cs_nxt = 1'b1;
          w_wn_nxt = m_write_n;
        end else begin
          w_state_nxt = ACK;
          w_capture   = 1'b1;
          w_ack0_nxt  = ~r_last_grant;
          w_ack1_nxt  = r_last_grant;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      m_chipselect <= w_cs_nxt;
      m_write_n    <= w_wn_nxt;
      m_address    <= w_addr_nxt;
      m_writedata  <= w_wdata_nxt;
      r0_ack       <= w_ack0_nxt;
      r1_ack       <= w_ack1_nxt;
      busy         <= (w_state_nxt != IDLE);
      // Read data is captured for writes too; each side holds its last value.
      if (w_capture && !r_last_grant) r0_rdata <= m_readdata;
      if (w_capture &&  r_last_grant) r1_rdata <= m_readdata;
    end
  end

endmodule

// File: tb/tb_nes_pio_arbiter.sv
// tb_nes_pio_arbiter: testbench for nes_pio_arbiter. Contains a small
// output-PIO slave (8-bit register at address 0, other addresses read 0),
// directed scenarios with literal expectations, and a randomized phase
// checked every cycle against a timeline model of the arbiter.
// Build option: NES_PIO_ARB_WAIT_EN adds a randomized m_waitrequest.
module tb_nes_pio_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic              req  [2];
  logic              wr   [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wd   [2];
  logic              ack  [2];
  logic [DATA_W-1:0] rdat [2];

  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write_n;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              busy;
`ifdef NES_PIO_ARB_WAIT_EN
  logic              m_waitrequest = 1'b0;
  bit                wait_rand_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: one transaction on a timeline of clock edges.
  bit                m_act  = 1'b0;
  bit                m_g    = 1'b0;
  bit                m_last = 1'b1;
  logic              t_wr;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wd;
  int                tend    = 0;
  int                ack_cyc = -10;
  int                next_s  = 0;
  logic [DATA_W-1:0] m_rd [2];
  logic [7:0]        mpio = 8'h00;
  logic [7:0]        pio  = 8'h00;

  nes_pio_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r0_req       (req[0]),
    .r0_wr        (wr[0]),
    .r0_addr      (addr[0]),
    .r0_wdata     (wd[0]),
    .r0_ack       (ack[0]),
    .r0_rdata     (rdat[0]),
    .r1_req       (req[1]),
    .r1_wr        (wr[1]),
    .r1_addr      (addr[1]),
    .r1_wdata     (wd[1]),
    .r1_ack       (ack[1]),
    .r1_rdata     (rdat[1]),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
`ifdef NES_PIO_ARB_WAIT_EN
    .m_waitrequest(m_waitrequest),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Output PIO slave: register at address 0, zero-wait combinational read.
  assign m_readdata = (m_address == 2'd0) ? {24'h0, pio} : 32'h0;
  always @(posedge clk) begin
`ifdef NES_PIO_ARB_WAIT_EN
    if (m_chipselect && !m_write_n && m_address == 2'd0 && !m_waitrequest)
`else
    if (m_chipselect && !m_write_n && m_address == 2'd0)
`endif
      pio <= m_writedata[7:0];
  end

`ifdef NES_PIO_ARB_WAIT_EN
  // Stall the slave until the edge the model chose to close the access.
  always @(negedge clk) m_waitrequest = m_act && (cyc + 1 < tend);
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Waits (bounded) for requester i's ack, then drops its request.
  task automatic wait_ack(input int i, input string name, input int exp_lat);
    int k;
    k = 0;
    while (k < 12) begin
      @(negedge clk);
      k++;
      if (ack[i]) break;
    end
    check(name, 32'(k), 32'(exp_lat));
    req[i] = 1'b0;
  endtask

  task automatic rand_fields(input int i);
    wr[i]   = 1'($urandom_range(0, 1));
    addr[i] = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
    wd[i]   = $urandom;
  endtask

  // Model update at each edge, then compare all outputs just after it.
  initial begin : model_cmp
    logic [DATA_W-1:0] rd;
    int wc;
    m_rd[0] = '0;
    m_rd[1] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_act   = 1'b0;
        m_last  = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
        ack_cyc = -10;
        next_s  = 0;
      end else if (m_act && cyc == tend) begin
        rd = (t_addr == 2'd0) ? {24'h0, mpio} : 32'h0;
        if (t_wr && t_addr == 2'd0) mpio = t_wd[7:0];
        m_rd[m_g] = rd;
        ack_cyc   = cyc;
        m_act     = 1'b0;
        next_s    = cyc + 2;
      end else if (!m_act && cyc >= next_s && (req[0] || req[1])) begin
        m_g    = (req[0] && req[1]) ? !m_last : req[1];
        m_last = m_g;
        t_wr   = wr[m_g];
        t_addr = addr[m_g];
        t_wd   = wd[m_g];
        m_act  = 1'b1;
        wc     = 0;
`ifdef NES_PIO_ARB_WAIT_EN
        if (wait_rand_en) wc = $urandom_range(0, 3);
`endif
        tend   = cyc + 1 + wc;
      end
      #1;
      check("m_cs",    32'(m_chipselect), 32'(m_act));
      check("m_wn",    32'(m_write_n),    32'(m_act ? !t_wr : 1'b1));
      check("busy",    32'(busy),         32'(m_act || ack_cyc == cyc));
      check("ack0",    32'(ack[0]),       32'(ack_cyc == cyc && m_g == 1'b0));
      check("ack1",    32'(ack[1]),       32'(ack_cyc == cyc && m_g == 1'b1));
      check("rdata0",  rdat[0], m_rd[0]);
      check("rdata1",  rdat[1], m_rd[1]);
      if (m_act) begin
        check("m_addr",  32'(m_address), 32'(t_addr));
        check("m_wdata", m_writedata,    t_wd);
      end
    end
  end

  initial begin : main
    int order[$];
    int rises[$];
    bit prev;
    int overlaps;
    int n_ab;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end

    // Reset values.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs",    32'(m_chipselect), 32'd0);
    check("rst_wn",    32'(m_write_n),    32'd1);
    check("rst_addr",  32'(m_address),    32'd0);
    check("rst_wdata", m_writedata,       32'd0);
    check("rst_ack0",  32'(ack[0]),       32'd0);
    check("rst_ack1",  32'(ack[1]),       32'd0);
    check("rst_rd0",   rdat[0],           32'd0);
    check("rst_rd1",   rdat[1],           32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    reset_n = 1'b1;

    // Single write of 0xA5; payload changed after grant must not matter.
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 2'd0; wd[0] = 32'h0000_00A5;
    @(negedge clk);
    check("wr_cs",    32'(m_chipselect), 32'd1);
    check("wr_wn",    32'(m_write_n),    32'd0);
    check("wr_wdata", m_writedata,       32'h0000_00A5);
    check("wr_busy",  32'(busy),         32'd1);
    req[0] = 1'b0; wd[0] = 32'hDEAD_BEEF; addr[0] = 2'd3;
    @(negedge clk);
    check("wr_ack0",  32'(ack[0]),       32'd1);
    check("wr_ack1",  32'(ack[1]),       32'd0);
    check("wr_cs_off", 32'(m_chipselect), 32'd0);
    @(negedge clk);
    check("wr_pio",   32'(pio),          32'h0000_00A5);
    check("wr_ack0_end", 32'(ack[0]),    32'd0);

    // Readback by requester 1 from addr 0, then addr 1.
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 2'd0;
    wait_ack(1, "rd0_lat", 2);
    check("rd0_data", rdat[1], 32'h0000_00A5);
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 2'd1;
    wait_ack(1, "rd1_lat", 2);
    check("rd1_data", rdat[1], 32'h0000_0000);
    @(negedge clk);

    // Contention from reset: both held high.
    reset_n = 1'b0;
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 2'd0; wd[0] = 32'h0000_005A;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;
    prev = 1'b0;
    overlaps = 0;
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      @(negedge clk);
      if (ack[0] && ack[1]) overlaps++;
      if (ack[0]) order.push_back(0);
      if (ack[1]) order.push_back(1);
      if (m_chipselect && !prev) rises.push_back(k);
      prev = m_chipselect;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check("cont_count",   32'(order.size()), 32'd4);
    check("cont_overlap", 32'(overlaps),     32'd0);
    for (int j = 0; j < 4; j++)
      if (j < order.size()) check("cont_order", 32'(order[j]), 32'(j % 2));
    for (int j = 1; j < 4; j++)
      if (j < rises.size()) check("cont_gap", 32'(rises[j] - rises[j-1]), 32'd3);
    check("cont_rd1", rdat[1], 32'h0000_005A);
    repeat (3) @(negedge clk);

    // Abort requester 1 during ACCESS, then re-grant the held request.
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 2'd0;
    @(negedge clk);
    check("ab_cs", 32'(m_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    check("ab_cs_async",   32'(m_chipselect), 32'd0);
    check("ab_busy_async", 32'(busy),         32'd0);
    n_ab = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack[1]) n_ab++;
    end
    check("ab_noack", 32'(n_ab), 32'd0);
    reset_n = 1'b1;
    wait_ack(1, "ab_regrant_lat", 2);
    check("ab_rd", rdat[1], 32'h0000_005A);

    // Randomized traffic, checked by the model every cycle.
`ifdef NES_PIO_ARB_WAIT_EN
    wait_rand_en = 1'b1;
`endif
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (k == 700) reset_n = 1'b0;
      if (k == 703) reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (ack_cyc == cyc && m_g == 1'(i)) begin
          req[i] = 1'($urandom_range(0, 1));
          if (req[i]) rand_fields(i);
        end else if (m_act && m_g == 1'(i)) begin
          if ($urandom_range(0, 3) == 0) rand_fields(i);
          if ($urandom_range(0, 4) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          rand_fields(i);
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
